// File: rtl/output_ram_reader_if.sv
// Valid/ready stream carrying words read back from the output RAM.
// The master drives data/valid, and the slave drives ready.
interface output_ram_reader_if #(
    parameter int n = 32
);
    logic [n-1:0] out_data;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/output_ram_reader.sv
// Streams output-RAM entries 0..len-1 to a valid/ready consumer.
// The RAM's one-cycle registered read latency is hidden inside the block.
module output_ram_reader #(
    parameter  int r  = 8,
    parameter  int n  = 32,
    localparam int aw = $clog2(r)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [aw:0]           len,
    output logic                  ram_rd,
    output logic [aw-1:0]         ram_addr,
    input  logic [n-1:0]          ram_dout,
    output_ram_reader_if.master   st,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        CAPTURE = 3'd2,
        SEND    = 3'd3,
        FIN     = 3'd4
    } state_t;

    localparam logic [aw:0] depth_c = (aw+1)'(r);
    localparam logic [aw:0] one_c   = {{aw{1'b0}}, 1'b1};

    state_t        state_r, state_s;
    logic [aw:0]   idx_r, idx_s;
    logic [aw:0]   cnt_r, cnt_s;
    logic [aw:0]   len_clamp_s;
    logic [n-1:0]  data_r, data_s;
    logic          ram_rd_r;
    logic          valid_r;
    logic          busy_r;
    logic          done_r;

    // Next-state, index/count and captured-data logic.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        cnt_s       = cnt_r;
        data_s      = data_r;
        len_clamp_s = (len > depth_c) ? depth_c : len;
        case (state_r)
            IDLE: begin
                if (start) begin
                    cnt_s   = len_clamp_s;
                    idx_s   = '0;
                    state_s = (len_clamp_s == '0) ? FIN : ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                state_s = CAPTURE;
            end
            CAPTURE: begin
                data_s  = ram_dout;
                state_s = SEND;
            end
            SEND: begin
                if (st.out_ready) begin
                    if (idx_r == cnt_r - one_c) begin
                        state_s = FIN;
                    end else begin
                        idx_s   = idx_r + one_c;
                        state_s = ISSUE;
                    end
                end else begin
                    state_s = SEND;
                end
            end
            FIN: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; strobes are decoded from the next state so they leave on flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            idx_r    <= '0;
            cnt_r    <= '0;
            data_r   <= '0;
            ram_rd_r <= 1'b0;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            idx_r    <= idx_s;
            cnt_r    <= cnt_s;
            data_r   <= data_s;
            ram_rd_r <= (state_s == ISSUE);
            valid_r  <= (state_s == SEND);
            busy_r   <= (state_s != IDLE);
            done_r   <= (state_s == FIN);
        end
    end

    assign ram_rd       = ram_rd_r;
    assign ram_addr     = idx_r[aw-1:0];
    assign st.out_data  = data_r;
    assign st.out_valid = valid_r;
    assign busy         = busy_r;
    assign done         = done_r;

endmodule

// File: tb/tb_output_ram_reader.sv
// Bench for output_ram_reader: table of directed bursts, a reset-abort sequence,
// and randomized bursts checked against a word-list/cycle-count reference model.
module tb_output_ram_reader;
    localparam int R  = 8;
    localparam int N  = 32;
    localparam int AW = $clog2(R);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   len;
    logic          ram_rd;
    logic [AW-1:0] ram_addr;
    logic [N-1:0]  ram_dout;
    logic          busy;
    logic          done;
    logic [N-1:0]  mem [R];

    int tests = 0;
    int fails = 0;

    output_ram_reader_if #(.n(N)) st ();

    output_ram_reader #(.r(R), .n(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .ram_rd   (ram_rd),
        .ram_addr (ram_addr),
        .ram_dout (ram_dout),
        .st       (st),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Registered-read RAM model
    always @(posedge clk) begin
        if (ram_rd) ram_dout <= mem[ram_addr];
    end

    typedef struct {
        int    len;
        int    stall_word;
        int    restart_cyc;
        int    exp_words;
        int    exp_done;
        string name;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Runs one burst, then checks it against the reference: words = mem[0..min(len,R)-1],
    // done cycle = 3k+1+stall cycles, one done, addresses in order, idle afterwards.
    task automatic run_burst(input int l, input int stall_word, input int restart_cyc,
                             input bit rnd, input int exp_words, input int exp_done,
                             input string tag);
        int k;
        int rd_cnt = 0, hs = 0, stalls = 0, done_cnt = 0, done_cyc = -1;
        int busy_cyc = 0, first_valid = -1, stall_in_word = 0;
        int overlap = 0, addr_err = 0, hold_err = 0;
        bit prev_stalled = 1'b0;
        logic [N-1:0] prev_data = '0;
        logic [N-1:0] words [$];
        k = (l > R) ? R : l;
        start = 1'b1;
        len = l[AW:0];
        st.out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 400 && done_cyc < 0; c++) begin
            start = (c == restart_cyc);
            if (c == restart_cyc) len = 1;
            if (rnd) st.out_ready = 1'($urandom_range(0, 1));
            else if (stall_word >= 0 && hs == stall_word && st.out_valid && stall_in_word < 5)
                st.out_ready = 1'b0;
            else st.out_ready = 1'b1;
            if (ram_rd) begin
                if (int'(ram_addr) != rd_cnt) addr_err++;
                if (st.out_valid) overlap++;
                rd_cnt++;
            end
            if (busy) busy_cyc++;
            if (st.out_valid) begin
                if (first_valid < 0) first_valid = c;
                if (prev_stalled && st.out_data != prev_data) hold_err++;
                if (st.out_ready) begin
                    words.push_back(st.out_data);
                    hs++;
                    prev_stalled = 1'b0;
                    stall_in_word = 0;
                end else begin
                    stalls++;
                    prev_stalled = 1'b1;
                    prev_data = st.out_data;
                    stall_in_word++;
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        st.out_ready = 1'b0;
        check({tag, " handshakes"}, hs, exp_words);
        check({tag, " done_count"}, done_cnt, 1);
        check({tag, " ram_rd_count"}, rd_cnt, k);
        check({tag, " addr_order_errs"}, addr_err, 0);
        check({tag, " rd_during_valid"}, overlap, 0);
        check({tag, " hold_errs"}, hold_err, 0);
        check({tag, " busy_cycles"}, busy_cyc, 3 * k + 1 + stalls);
        if (rnd) check({tag, " done_cycle"}, done_cyc, 3 * k + 1 + stalls);
        else begin
            check({tag, " done_cycle"}, done_cyc, exp_done);
            check({tag, " stall_cycles"}, stalls, (stall_word >= 0) ? 5 : 0);
        end
        if (k > 0) check({tag, " first_valid_cycle"}, first_valid, 3);
        for (int i = 0; i < words.size() && i < R; i++)
            check($sformatf("%s word%0d", tag, i), words[i], mem[i]);
        check({tag, " idle_busy"}, busy, 0);
        check({tag, " idle_done"}, done, 0);
    endtask

    initial begin
        vec_t vecs [7];
        int   seen;
        vecs[0] = '{3, -1, -1, 3, 10, "len3"};
        vecs[1] = '{3,  1, -1, 3, 15, "len3_stall"};
        vecs[2] = '{12, -1, -1, 8, 25, "len12_clamp"};
        vecs[3] = '{0, -1, -1, 0, 1, "len0"};
        vecs[4] = '{3, -1, 4, 3, 10, "restart_ignored"};
        vecs[5] = '{8, -1, -1, 8, 25, "len8_full"};
        vecs[6] = '{1, -1, -1, 1, 4, "len1"};

        mem = '{32'd10, 32'd2, 32'd4, 32'd7, 32'd9, 32'd11, 32'd13, 32'd15};
        rst = 1'b1;
        start = 1'b0;
        len = '0;
        st.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ram_rd", ram_rd, 0);
        check("reset ram_addr", ram_addr, 0);
        check("reset out_data", st.out_data, 0);
        check("reset out_valid", st.out_valid, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i])
            run_burst(vecs[i].len, vecs[i].stall_word, vecs[i].restart_cyc, 1'b0,
                      vecs[i].exp_words, vecs[i].exp_done, vecs[i].name);

        // Reset while the first word is being offered abandons the burst silently.
        start = 1'b1;
        len = 3;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 10 && !st.out_valid; c++) begin
            @(posedge clk); #1;
        end
        check("rst reached SEND", st.out_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst out_valid", st.out_valid, 0);
        check("rst busy", busy, 0);
        check("rst out_data", st.out_data, 0);
        check("rst done", done, 0);
        check("rst ram_addr", ram_addr, 0);
        for (int c = 0; c < 4; c++) begin
            if (done || busy || ram_rd) seen++;
            @(posedge clk); #1;
        end
        check("rst stays idle", seen, 0);
        run_burst(2, -1, -1, 1'b0, 2, 7, "after_rst");

        // Randomized bursts against the reference model
        for (int t = 0; t < 20; t++) begin
            int l;
            foreach (mem[i]) mem[i] = $urandom;
            l = $urandom_range(0, 15);
            run_burst(l, -1, -1, 1'b1, (l > R) ? R : l, 0, $sformatf("rnd%0d_len%0d", t, l));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
